// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared op codes, flag bundle and helpers
// for the round-robin ALU scheduler.
package alu_sched_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
    localparam logic [OP_W-1:0] OP_MULT = 4'd8;
    localparam logic [OP_W-1:0] OP_DIV  = 4'd9;

    typedef struct packed {
        logic error;
        logic overflow;
        logic negative;
        logic zero;
    } alu_flags_t;

    function automatic alu_flags_t mk_flags(
        input logic err,
        input logic ovf,
        input logic neg,
        input logic zro
    );
        alu_flags_t f;
        f.error    = err;
        f.overflow = ovf;
        f.negative = neg;
        f.zero     = zro;
        return f;
    endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among eligible
// requesters, searching upward from ptr with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_eligible,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // first eligible requester at or after the pointer wins
    always_comb begin
        int idx;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!o_valid && i_eligible[idx]) begin
                o_valid      = 1'b1;
                o_grant[idx] = 1'b1;
                o_idx        = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one registered ALU among NUM_REQ requesters,
// one op in flight per requester, result held in a private slot.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*4-1:0]    req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [NUM_REQ*WIDTH-1:0] rsp_result,
    output logic [NUM_REQ*4-1:0]    rsp_flags,
    output logic [OP_W-1:0]         alu_op,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic                    alu_overflow,
    input  logic                    alu_error,
    output logic                    busy
);

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_inflight_v;
    logic [ID_W-1:0]    r_inflight_id;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_result [NUM_REQ];
    alu_flags_t         r_rsp_flags  [NUM_REQ];

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gidx;
    logic               w_gvalid;
    alu_flags_t         w_cap_flags;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign w_elig[i] = req_valid[i]
                         & ~r_rsp_valid[i]
                         & ~(r_inflight_v
                             && r_inflight_id == ID_W'(i));
        assign rsp_result[i*WIDTH +: WIDTH] = r_rsp_result[i];
        assign rsp_flags[i*4 +: 4]          = r_rsp_flags[i];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .i_eligible (w_elig),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_idx      (w_gidx),
        .o_valid    (w_gvalid)
    );

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign busy      = r_inflight_v | (|r_rsp_valid);

    // zero/negative come from the captured result, not the ALU
    assign w_cap_flags = mk_flags(alu_error, alu_overflow,
                                  alu_result[WIDTH-1],
                                  alu_result == '0);

    // steer granted operands to the ALU; idle cycles issue ADD 0,0
    always_comb begin
        alu_op = OP_ADD;
        alu_a  = '0;
        alu_b  = '0;
        if (w_gvalid) begin
            alu_op = req_op[w_gidx*OP_W +: OP_W];
            alu_a  = req_a[w_gidx*WIDTH +: WIDTH];
            alu_b  = req_b[w_gidx*WIDTH +: WIDTH];
        end
    end

    // round-robin pointer and in-flight tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_inflight_v  <= 1'b0;
            r_inflight_id <= '0;
        end else begin
            r_inflight_v <= w_gvalid;
            if (w_gvalid) begin
                r_inflight_id <= w_gidx;
                if (w_gidx == ID_W'(NUM_REQ-1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_gidx + 1'b1;
                end
            end
        end
    end

    // response slots: capture ALU output, release on rsp_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rsp_result[i] <= '0;
                r_rsp_flags[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_inflight_v && r_inflight_id == ID_W'(i)) begin
                    r_rsp_valid[i]  <= 1'b1;
                    r_rsp_result[i] <= alu_result;
                    r_rsp_flags[i]  <= w_cap_flags;
                end else if (rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    // a slot is never full when its op comes back
    a_no_overwrite: assert property (
        @(posedge clk) disable iff (rst)
        !(r_inflight_v && r_rsp_valid[r_inflight_id])
    );

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed checks of the ALU scheduler with a
// behavioural registered ALU attached.
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*4-1:0] req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [N*W-1:0] rsp_result;
    logic [N*4-1:0] rsp_flags;
    logic [3:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_result;
    logic           alu_overflow;
    logic           alu_error;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int gcount;

    always #5 clk = ~clk;

    alu_sched #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_error    (alu_error),
        .busy         (busy)
    );

    // behavioural ALU, one cycle latency
    logic [W-1:0] m_res;
    logic         m_ovf;
    logic         m_err;

    always_comb begin
        m_res = '0;
        m_ovf = 1'b0;
        m_err = 1'b0;
        case (alu_op)
            OP_ADD: begin
                m_res = alu_a + alu_b;
                m_ovf = (alu_a[W-1] == alu_b[W-1])
                     && (m_res[W-1] != alu_a[W-1]);
            end
            OP_SUB: begin
                m_res = alu_a - alu_b;
                m_ovf = (alu_a[W-1] != alu_b[W-1])
                     && (m_res[W-1] != alu_a[W-1]);
            end
            OP_AND:  m_res = alu_a & alu_b;
            OP_OR:   m_res = alu_a | alu_b;
            OP_XOR:  m_res = alu_a ^ alu_b;
            OP_SLL:  m_res = alu_a << alu_b[4:0];
            OP_SRL:  m_res = alu_a >> alu_b[4:0];
            OP_SRA:  m_res = $signed(alu_a) >>> alu_b[4:0];
            OP_MULT: m_res = alu_a * alu_b;
            OP_DIV: begin
                if (alu_b == '0) begin
                    m_res = '1;
                    m_err = 1'b1;
                end else begin
                    m_res = alu_a / alu_b;
                end
            end
            default: m_err = 1'b1;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result   <= '0;
            alu_overflow <= 1'b0;
            alu_error    <= 1'b0;
        end else begin
            alu_result   <= m_res;
            alu_overflow <= m_ovf;
            alu_error    <= m_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i,
                           input logic [3:0] op,
                           input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_op[i*4 +: 4] = op;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_valid[i]     = 1'b1;
    endtask

    // lone op on requester i, response popped at once
    task automatic run_op(input string tag,
                          input int i,
                          input logic [3:0] op,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] eres,
                          input logic [3:0] eflg);
        logic [N-1:0] oh;
        oh = 4'b0001 << i;
        set_req(i, op, a, b);
        #1;
        chk({tag, ":grant"}, req_ready, oh);
        tick();
        req_valid[i] = 1'b0;
        #1;
        chk({tag, ":lat"}, rsp_valid, 0);
        tick();
        chk({tag, ":vld"}, rsp_valid, oh);
        chk({tag, ":res"}, rsp_result[i*W +: W], eres);
        chk({tag, ":flg"}, rsp_flags[i*4 +: 4], eflg);
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 4'hF;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);

        chk("rst:vld", rsp_valid, 0);
        chk("rst:busy", busy, 0);
        chk("rst:res", rsp_result, 0);
        chk("rst:flg", rsp_flags, 0);
        chk("rst:alu", {alu_op, alu_a, alu_b}, 0);
        rst = 1'b0;
        tick();

        // single ADD with latency and busy
        set_req(0, OP_ADD, 32'd5, 32'd7);
        #1;
        chk("one:grant", req_ready, 4'b0001);
        chk("one:alu", {alu_op, alu_a, alu_b},
            {4'd0, 32'd5, 32'd7});
        tick();
        req_valid[0] = 1'b0;
        #1;
        chk("one:lat", rsp_valid, 0);
        chk("one:busy", busy, 1);
        tick();
        chk("one:vld", rsp_valid, 4'b0001);
        chk("one:res", rsp_result[31:0], 32'd12);
        chk("one:flg", rsp_flags[3:0], 4'b0000);
        tick();
        chk("one:pop", {busy, rsp_valid}, 0);

        // flag and error cases
        run_op("zero", 1, OP_SUB, 32'd3, 32'd3,
               32'd0, 4'b0001);
        run_op("neg", 2, OP_SUB, 32'd0, 32'd1,
               32'hFFFF_FFFF, 4'b0010);
        run_op("ovf", 3, OP_ADD, 32'h7FFF_FFFF, 32'd1,
               32'h8000_0000, 4'b0110);
        run_op("div0", 0, OP_DIV, 32'd9, 32'd0,
               32'hFFFF_FFFF, 4'b1010);
        run_op("badop", 1, 4'hF, 32'd4, 32'd5,
               32'd0, 4'b1001);
        run_op("xor", 3, OP_XOR, 32'hF0F0, 32'hFF00,
               32'h0FF0, 4'b0000);

        // contention, pointer back at 0
        for (int i = 0; i < N; i++) begin
            set_req(i, OP_ADD, W'(i * 10), 32'd1);
        end
        #1;
        chk("rr:g0", req_ready, 4'b0001);
        tick();
        chk("rr:g1", req_ready, 4'b0010);
        tick();
        chk("rr:g2", {req_ready, rsp_valid}, {4'b0100, 4'b0001});
        chk("rr:r0", rsp_result[0*W +: W], 32'd1);
        tick();
        chk("rr:g3", {req_ready, rsp_valid}, {4'b1000, 4'b0010});
        chk("rr:r1", rsp_result[1*W +: W], 32'd11);
        tick();
        chk("rr:wrap", {req_ready, rsp_valid}, {4'b0001, 4'b0100});
        chk("rr:r2", rsp_result[2*W +: W], 32'd21);
        req_valid = '0;
        tick();
        chk("rr:r3", {rsp_valid, rsp_result[3*W +: W]},
            {4'b1000, 32'd31});
        tick();
        chk("rr:idle", busy, 0);

        // backpressure on slot 2
        rsp_ready = 4'b1011;
        set_req(2, OP_SUB, 32'd100, 32'd58);
        #1;
        chk("bp:g2", req_ready, 4'b0100);
        tick();
        set_req(0, OP_ADD, 32'd1, 32'd2);
        #1;
        chk("bp:g0", req_ready, 4'b0001);
        tick();
        gcount = 0;
        for (int k = 0; k < 10; k++) begin
            chk("bp:hold",
                {req_ready[2], rsp_valid[2], rsp_result[2*W +: W]},
                {1'b0, 1'b1, 32'd42});
            if (req_ready[0]) gcount++;
            tick();
        end
        chk("bp:served", gcount, 3);
        req_valid[0] = 1'b0;
        rsp_ready    = 4'hF;
        tick();
        chk("bp:regrant", {req_ready, rsp_valid}, {4'b0100, 4'b0000});
        req_valid[2] = 1'b0;
        tick();
        chk("bp:idle", busy, 0);

        // reset one cycle after acceptance
        set_req(1, OP_ADD, 32'd1, 32'd1);
        #1;
        chk("mr:g1", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr:out", {busy, rsp_valid, rsp_flags}, 0);
        chk("mr:res", rsp_result, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr:drop", {busy, rsp_valid}, 0);
        for (int i = 0; i < N; i++) begin
            set_req(i, OP_AND, 32'hF, 32'h3);
        end
        #1;
        chk("mr:ptr0", req_ready, 4'b0001);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
